int2float_pipe: RTL and testbench

- Parametrised, pipelined unsigned/signed integer-to-minifloat converter; the sequential successor of the team's combinational 11-bit to 7-bit int2float block.
- Width, exponent and mantissa fields are generic. Adds optional sign handling, per-sample rounding mode, exception flags and a valid/ready stream interface.
- Sits between integer datapath producers and the float packing/logic-synthesis benchmark harness.

---
 rtl/int2float_pipe.sv | 177 +++++++++++++++++
 tb/tb_int2float_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/int2float_pipe.sv
// Three-stage pipelined integer to minifloat converter with valid/ready flow
// control, per-sample truncate/round-to-nearest-even and saturation flags.
module int2float_pipe #(
    parameter int IN_W   = 11,
    parameter int EXP_W  = 3,
    parameter int MAN_W  = 4,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_rnd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SIGNED+EXP_W+MAN_W-1:0] out_data,
    output logic                          out_inexact,
    output logic                          out_ovf
);
    localparam int OUT_W = SIGNED + EXP_W + MAN_W;
    localparam int PW    = $clog2(IN_W) + 1;
    localparam int XW    = (PW + 1 > EXP_W + 1) ? PW + 1 : EXP_W + 1;
    localparam int NW    = IN_W + 2;
    localparam logic [XW-1:0] EXP_MAX = {{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

    logic             adv1, adv2, adv3;

    logic             v1_q, v1_d;
    logic [IN_W-1:0]  mag1_q, mag1_d;
    logic             sgn1_q, sgn1_d;
    logic             rnd1_q, rnd1_d;
    logic             neg1;

    logic             v2_q, v2_d;
    logic [XW-1:0]    exp2_q, exp2_d;
    logic [MAN_W-1:0] man2_q, man2_d;
    logic             grd2_q, grd2_d;
    logic             stk2_q, stk2_d;
    logic             sgn2_q, sgn2_d;
    logic             rnd2_q, rnd2_d;
    logic [PW-1:0]    lead;
    logic [NW-1:0]    shifted;

    logic             v3_q, v3_d;
    logic [OUT_W-1:0] data3_q, data3_d;
    logic             inx3_q, inx3_d;
    logic             ovf3_q, ovf3_d;
    logic             rup, carry, sat;
    logic [MAN_W-1:0] man_r, man_o;
    logic [XW-1:0]    exp_r;
    logic [EXP_W-1:0] exp_o;
    logic [OUT_W-1:0] res3;

    // A stage may load when its own slot is empty or its content moves on.
    always_comb begin
        adv3 = !v3_q || out_ready;
        adv2 = !v2_q || adv3;
        adv1 = !v1_q || adv2;
    end

    assign in_ready    = adv1;
    assign out_valid   = v3_q;
    assign out_data    = data3_q;
    assign out_inexact = inx3_q;
    assign out_ovf     = ovf3_q;

    always_comb begin
        v1_d   = adv1 ? in_valid : v1_q;
        mag1_d = mag1_q;
        sgn1_d = sgn1_q;
        rnd1_d = rnd1_q;
        neg1   = (SIGNED != 0) && in_data[IN_W-1];
        if (adv1 && in_valid) begin
            mag1_d = neg1 ? (IN_W'(0) - in_data) : in_data;
            sgn1_d = neg1;
            rnd1_d = in_rnd;
        end
    end

    // Shift so the leading one falls off the top; what remains is man|guard|sticky.
    always_comb begin
        lead = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag1_q[i]) lead = PW'(i);
        end
        shifted = {mag1_q, 2'b00} << (PW'(IN_W) - lead);

        v2_d   = adv2 ? v1_q : v2_q;
        exp2_d = exp2_q;
        man2_d = man2_q;
        grd2_d = grd2_q;
        stk2_d = stk2_q;
        sgn2_d = sgn2_q;
        rnd2_d = rnd2_q;
        if (adv2 && v1_q) begin
            sgn2_d = sgn1_q;
            rnd2_d = rnd1_q;
            if (lead < PW'(MAN_W)) begin
                exp2_d = '0;
                man2_d = mag1_q[MAN_W-1:0];
                grd2_d = 1'b0;
                stk2_d = 1'b0;
            end else begin
                exp2_d = XW'(lead) - XW'(MAN_W - 1);
                man2_d = shifted[NW-1 -: MAN_W];
                grd2_d = shifted[NW-1-MAN_W];
                stk2_d = |shifted[NW-2-MAN_W:0];
            end
        end
    end

    always_comb begin
        rup            = rnd2_q && grd2_q && (stk2_q || man2_q[0]);
        {carry, man_r} = {1'b0, man2_q} + {{MAN_W{1'b0}}, rup};
        exp_r          = exp2_q + {{(XW-1){1'b0}}, carry};
        sat            = exp_r > EXP_MAX;
        exp_o          = sat ? {EXP_W{1'b1}} : exp_r[EXP_W-1:0];
        man_o          = sat ? {MAN_W{1'b1}} : man_r;
    end

    generate
        if (SIGNED != 0) begin : g_signed
            assign res3 = {sgn2_q, exp_o, man_o};
        end else begin : g_unsigned
            assign res3 = {exp_o, man_o};
        end
    endgenerate

    always_comb begin
        v3_d    = adv3 ? v2_q : v3_q;
        data3_d = data3_q;
        inx3_d  = inx3_q;
        ovf3_d  = ovf3_q;
        if (adv3 && v2_q) begin
            data3_d = res3;
            inx3_d  = grd2_q || stk2_q;
            ovf3_d  = sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            mag1_q  <= '0;
            sgn1_q  <= 1'b0;
            rnd1_q  <= 1'b0;
            v2_q    <= 1'b0;
            exp2_q  <= '0;
            man2_q  <= '0;
            grd2_q  <= 1'b0;
            stk2_q  <= 1'b0;
            sgn2_q  <= 1'b0;
            rnd2_q  <= 1'b0;
            v3_q    <= 1'b0;
            data3_q <= '0;
            inx3_q  <= 1'b0;
            ovf3_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            mag1_q  <= mag1_d;
            sgn1_q  <= sgn1_d;
            rnd1_q  <= rnd1_d;
            v2_q    <= v2_d;
            exp2_q  <= exp2_d;
            man2_q  <= man2_d;
            grd2_q  <= grd2_d;
            stk2_q  <= stk2_d;
            sgn2_q  <= sgn2_d;
            rnd2_q  <= rnd2_d;
            v3_q    <= v3_d;
            data3_q <= data3_d;
            inx3_q  <= inx3_d;
            ovf3_q  <= ovf3_d;
        end
    end
endmodule

// File: tb/tb_int2float_pipe.sv
// Directed bench for int2float_pipe: one unsigned and one signed instance,
// hand-computed expected results checked with immediate assertions.
module tb_int2float_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        in_valid_a, in_ready_a, in_rnd_a, out_valid_a, out_ready_a;
    logic [10:0] in_data_a;
    logic [6:0]  out_data_a;
    logic        out_inexact_a, out_ovf_a;

    logic        in_valid_b, in_ready_b, in_rnd_b, out_valid_b, out_ready_b;
    logic [10:0] in_data_b;
    logic [7:0]  out_data_b;
    logic        out_inexact_b, out_ovf_b;

    typedef struct {
        logic [7:0] d;
        logic       inx;
        logic       ovf;
        int         cyc;
    } ent_t;
    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_rnd(in_rnd_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_inexact(out_inexact_a), .out_ovf(out_ovf_a)
    );

    int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_rnd(in_rnd_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_inexact(out_inexact_b), .out_ovf(out_ovf_b)
    );

    // Output transfers, recorded between clock edges.
    always @(negedge clk) begin
        if (out_valid_a && out_ready_a)
            qa.push_back('{d: {1'b0, out_data_a}, inx: out_inexact_a, ovf: out_ovf_a, cyc: cyc});
        if (out_valid_b && out_ready_b)
            qb.push_back('{d: out_data_b, inx: out_inexact_b, ovf: out_ovf_b, cyc: cyc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one sample from posedge+1 and hold it until it is accepted.
    task automatic push(input bit ub, input logic [10:0] d, input logic r, output int acc);
        acc = -1;
        if (ub) begin in_valid_b = 1'b1; in_data_b = d; in_rnd_b = r; end
        else    begin in_valid_a = 1'b1; in_data_a = d; in_rnd_a = r; end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((ub ? in_ready_b : in_ready_a) === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        chk("accepted", {31'b0, acc >= 0}, 32'd1);
        @(posedge clk);
        #1;
        if (ub) in_valid_b = 1'b0;
        else    in_valid_a = 1'b0;
    endtask

    task automatic drain(input bit ub, input int n, input string tag);
        for (int k = 0; k < 60; k++) begin
            if ((ub ? qb.size() : qa.size()) >= n) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, ub ? qb.size() : qa.size(), n);
    endtask

    task automatic expect_q(input bit ub, input int i, input logic [7:0] d,
                            input logic inx, input logic ovf, input string tag);
        ent_t e;
        if (i < (ub ? qb.size() : qa.size())) begin
            e = ub ? qb[i] : qa[i];
            $display("txn %s[%0d] data=0x%02h inexact=%0d ovf=%0d", tag, i, e.d, e.inx, e.ovf);
            chk($sformatf("%s_out%0d", tag, i), {22'b0, e.d, e.inx, e.ovf}, {22'b0, d, inx, ovf});
        end
    endtask

    int acc0, acc;

    initial begin
        rst_n = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0; in_rnd_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; in_rnd_b = 1'b0; out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
        chk("rst_out_data", {25'b0, out_data_a}, 32'd0);
        chk("rst_flags", {30'b0, out_inexact_a, out_ovf_a}, 32'd0);
        chk("rst_in_ready", {30'b0, in_ready_a, in_ready_b}, 32'd3);
        @(posedge clk); #1;

        // Back-to-back truncation, latency and throughput
        qa.delete();
        push(0, 11'd0, 1'b0, acc0);
        push(0, 11'd13, 1'b0, acc);
        push(0, 11'd16, 1'b0, acc);
        push(0, 11'd25, 1'b0, acc);
        push(0, 11'd50, 1'b0, acc);
        drain(0, 5, "trunc");
        if (qa.size() == 5) begin
            chk("latency", qa[0].cyc - acc0, 32'd3);
            chk("throughput", qa[4].cyc - qa[0].cyc, 32'd4);
        end
        expect_q(0, 0, 8'h00, 0, 0, "trunc");
        expect_q(0, 1, 8'h0D, 0, 0, "trunc");
        expect_q(0, 2, 8'h10, 0, 0, "trunc");
        expect_q(0, 3, 8'h19, 0, 0, "trunc");
        expect_q(0, 4, 8'h29, 0, 0, "trunc");
        @(posedge clk); #1;

        // Rounding ties, carry into exponent, saturation
        qa.delete();
        push(0, 11'd51, 1'b1, acc);
        push(0, 11'd49, 1'b1, acc);
        push(0, 11'd63, 1'b1, acc);
        push(0, 11'd51, 1'b0, acc);
        push(0, 11'd2047, 1'b0, acc);
        push(0, 11'd2047, 1'b1, acc);
        push(0, 11'd1024, 1'b0, acc);
        drain(0, 7, "rnd");
        expect_q(0, 0, 8'h2A, 1, 0, "rnd");
        expect_q(0, 1, 8'h28, 1, 0, "rnd");
        expect_q(0, 2, 8'h30, 1, 0, "rnd");
        expect_q(0, 3, 8'h29, 1, 0, "rnd");
        expect_q(0, 4, 8'h7F, 1, 0, "rnd");
        expect_q(0, 5, 8'h7F, 1, 1, "rnd");
        expect_q(0, 6, 8'h70, 0, 0, "rnd");
        @(posedge clk); #1;

        // Signed instance
        qb.delete();
        push(1, 11'h7F0, 1'b0, acc);
        push(1, 11'h400, 1'b0, acc);
        push(1, 11'h000, 1'b0, acc);
        push(1, 11'h005, 1'b0, acc);
        push(1, 11'h7FF, 1'b1, acc);
        push(1, 11'h7CD, 1'b1, acc);
        drain(1, 6, "sgn");
        expect_q(1, 0, 8'h90, 0, 0, "sgn");
        expect_q(1, 1, 8'hF0, 0, 0, "sgn");
        expect_q(1, 2, 8'h00, 0, 0, "sgn");
        expect_q(1, 3, 8'h05, 0, 0, "sgn");
        expect_q(1, 4, 8'h81, 0, 0, "sgn");
        expect_q(1, 5, 8'hAA, 1, 0, "sgn");
        @(posedge clk); #1;

        // Backpressure: three buffered, fourth refused until drain
        qa.delete();
        out_ready_a = 1'b0;
        push(0, 11'd100, 1'b0, acc);
        push(0, 11'd200, 1'b0, acc);
        push(0, 11'd300, 1'b0, acc);
        in_valid_a = 1'b1; in_data_a = 11'd7; in_rnd_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_ready_low", {31'b0, in_ready_a}, 32'd0);
            chk("bp_hold", {24'b0, out_valid_a, out_data_a}, {24'b0, 1'b1, 7'h39});
        end
        chk("bp_no_output", qa.size(), 32'd0);
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        @(negedge clk);
        chk("bp_fill_drain", {31'b0, in_ready_a}, 32'd1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        drain(0, 4, "bp");
        if (qa.size() == 4) chk("bp_no_bubble", qa[3].cyc - qa[0].cyc, 32'd3);
        expect_q(0, 0, 8'h39, 0, 0, "bp");
        expect_q(0, 1, 8'h49, 0, 0, "bp");
        expect_q(0, 2, 8'h52, 1, 0, "bp");
        expect_q(0, 3, 8'h07, 0, 0, "bp");
        @(posedge clk); #1;

        // Reset with two samples in flight
        qa.delete();
        out_ready_a = 1'b0;
        push(0, 11'd2047, 1'b1, acc);
        push(0, 11'd51, 1'b1, acc);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_out", {22'b0, out_valid_a, out_data_a, out_inexact_a, out_ovf_a},
            {22'b0, 1'b1, 7'h7F, 1'b1, 1'b1});
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out", {22'b0, out_valid_a, out_data_a, out_inexact_a, out_ovf_a}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, in_ready_a}, 32'd1);
        out_ready_a = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_no_stale", qa.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
